// File: rtl/frame_buffer_ring_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// frame_buffer_ring_pkg : shared buffer-role types and sizing for the ring
// Revision 1.0
// ----------------------------------------------------------------------------
`ifndef COLOR_BITS
`define COLOR_BITS 8
`endif
`ifndef ADDR_BITS
`define ADDR_BITS 6
`endif

package frame_buffer_ring_pkg;
   localparam int          BUF_IDX_W = 2;
   localparam logic [15:0] DROP_MAX  = 16'hFFFF;

   typedef enum logic [1:0] {
      ROLE_FREE    = 2'd0,
      ROLE_DISPLAY = 2'd1,
      ROLE_WRITE   = 2'd2,
      ROLE_READY   = 2'd3
   } buf_role_e;
endpackage
`default_nettype wire

// File: rtl/fb_role_tracker.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fb_role_tracker : DISPLAY/WRITE/READY/FREE role rotation, swap handshake
// Revision 1.0
// ----------------------------------------------------------------------------
module fb_role_tracker
   import frame_buffer_ring_pkg::*;
#(
   parameter int NUM_BUFS = 3
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 frame_start,
   input  logic                 swap_req,
   output logic                 swap_ack,
   output logic [BUF_IDX_W-1:0] disp_idx,
   output logic [BUF_IDX_W-1:0] write_sel,
   output logic [15:0]          drop_count
);
   buf_role_e            role_q [NUM_BUFS];
   buf_role_e            role_d [NUM_BUFS];
   logic                 pending_q, pending_d;
   logic                 busy_q, busy_d;
   logic                 ack_q, ack_d;
   logic [15:0]          drop_q, drop_d;
   logic [BUF_IDX_W-1:0] wsel_q, wsel_d;
   logic [BUF_IDX_W-1:0] disp_cur, write_cur;
   logic                 want, accept, placed, has_ready;

   always_comb begin
      disp_cur  = '0;
      write_cur = '0;
      for (int i = 0; i < NUM_BUFS; i++) begin
         if (role_q[i] == ROLE_DISPLAY) disp_cur  = i[BUF_IDX_W-1:0];
         if (role_q[i] == ROLE_WRITE)   write_cur = i[BUF_IDX_W-1:0];
      end
   end

   always_comb begin
      role_d    = role_q;
      pending_d = pending_q;
      drop_d    = drop_q;
      wsel_d    = write_cur;
      accept    = 1'b0;
      placed    = 1'b0;
      has_ready = 1'b0;
      want      = swap_req & ~busy_q & ~pending_q;
      if (rst) begin
         for (int i = 0; i < NUM_BUFS; i++) begin
            role_d[i] = ROLE_FREE;
            if (i == 0) role_d[i] = ROLE_DISPLAY;
            if (i == 1) role_d[i] = ROLE_WRITE;
         end
         pending_d = 1'b0;
         drop_d    = '0;
         wsel_d    = BUF_IDX_W'(1);
      end else if (NUM_BUFS == 2) begin
         // No spare buffer: the finished frame can only be shown by a straight
         // exchange with the display buffer at the vsync boundary.
         if ((want | pending_q) & frame_start) begin
            for (int i = 0; i < NUM_BUFS; i++) begin
               if (role_q[i] == ROLE_DISPLAY)    role_d[i] = ROLE_WRITE;
               else if (role_q[i] == ROLE_WRITE) role_d[i] = ROLE_DISPLAY;
            end
            pending_d = 1'b0;
            accept    = 1'b1;
         end else if (want) begin
            pending_d = 1'b1;
         end
      end else begin
         if (want) begin
            for (int i = 0; i < NUM_BUFS; i++) begin
               if (role_q[i] == ROLE_READY) begin
                  role_d[i] = ROLE_FREE;
                  if (drop_q != DROP_MAX) drop_d = drop_q + 16'd1;
               end else if (role_q[i] == ROLE_WRITE) begin
                  role_d[i] = ROLE_READY;
               end
            end
            for (int i = 0; i < NUM_BUFS; i++) begin
               if (!placed && role_d[i] == ROLE_FREE) begin
                  role_d[i] = ROLE_WRITE;
                  placed    = 1'b1;
               end
            end
            accept = 1'b1;
         end
         // Promotion sees the post-swap roles, so a frame finished this cycle
         // goes straight to display.
         for (int i = 0; i < NUM_BUFS; i++) begin
            if (role_d[i] == ROLE_READY) has_ready = 1'b1;
         end
         if (frame_start && has_ready) begin
            for (int i = 0; i < NUM_BUFS; i++) begin
               if (role_d[i] == ROLE_DISPLAY)    role_d[i] = ROLE_FREE;
               else if (role_d[i] == ROLE_READY) role_d[i] = ROLE_DISPLAY;
            end
         end
      end
      // A request seen in reset counts as consumed and must drop first.
      busy_d = rst ? swap_req : (swap_req & (busy_q | accept));
      ack_d  = accept & ~rst;
   end

   always_ff @(posedge clk) begin
      role_q    <= role_d;
      pending_q <= pending_d;
      busy_q    <= busy_d;
      ack_q     <= ack_d;
      drop_q    <= drop_d;
      wsel_q    <= wsel_d;
   end

   assign swap_ack   = ack_q;
   assign disp_idx   = disp_cur;
   assign write_sel  = wsel_q;
   assign drop_count = drop_q;
endmodule
`default_nettype wire

// File: rtl/xilinx_true_dual_port_read_first_1_clock_ram.sv
`default_nettype none
// ----------------------------------------------------------------------------
// xilinx_true_dual_port_read_first_1_clock_ram : single-clock read-first TDP RAM
// Revision 1.0
// ----------------------------------------------------------------------------
module xilinx_true_dual_port_read_first_1_clock_ram #(
   parameter int RAM_WIDTH = 8,
   parameter int RAM_DEPTH = 64,
   parameter int ADDR_LEN  = 6
) (
   input  logic                 clka,
   input  logic [ADDR_LEN-1:0]  addra,
   input  logic [ADDR_LEN-1:0]  addrb,
   input  logic [RAM_WIDTH-1:0] dina,
   input  logic [RAM_WIDTH-1:0] dinb,
   input  logic                 wea,
   input  logic                 web,
   input  logic                 ena,
   input  logic                 enb,
   output logic [RAM_WIDTH-1:0] douta,
   output logic [RAM_WIDTH-1:0] doutb
);
   logic [RAM_WIDTH-1:0] mem_q [RAM_DEPTH];
   logic [RAM_WIDTH-1:0] douta_q;
   logic [RAM_WIDTH-1:0] doutb_q;

   // Read-first: each port returns the word held before its own write.
   always_ff @(posedge clka) begin
      if (ena) begin
         if (wea) mem_q[addra] <= dina;
         douta_q <= mem_q[addra];
      end
      if (enb) begin
         if (web) mem_q[addrb] <= dinb;
         doutb_q <= mem_q[addrb];
      end
   end

   assign douta = douta_q;
   assign doutb = doutb_q;
endmodule
`default_nettype wire

// File: rtl/frame_buffer_ring.sv
`default_nettype none
// ----------------------------------------------------------------------------
// frame_buffer_ring : NUM_BUFS-deep frame store with writer/display role ring
// Revision 1.0
// ----------------------------------------------------------------------------
module frame_buffer_ring
   import frame_buffer_ring_pkg::*;
#(
   parameter int WIDTH    = `COLOR_BITS,
   parameter int DEPTH    = 1 << `ADDR_BITS,
   parameter int ADDR_LEN = `ADDR_BITS,
   parameter int NUM_BUFS = 3
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 frame_start,
   input  logic                 swap_req,
   output logic                 swap_ack,
   input  logic                 write_enable,
   input  logic [ADDR_LEN-1:0]  write_addr,
   input  logic [WIDTH-1:0]     write_data,
   input  logic [ADDR_LEN-1:0]  read_addr,
   output logic [WIDTH-1:0]     read_data_out,
   output logic [BUF_IDX_W-1:0] read_buf_out,
   output logic [BUF_IDX_W-1:0] write_buf_out,
   output logic [15:0]          drop_count
);
   logic [BUF_IDX_W-1:0] disp_idx;
   logic [BUF_IDX_W-1:0] write_sel;
   logic [WIDTH-1:0]     ram_dout [NUM_BUFS];

   fb_role_tracker #(.NUM_BUFS(NUM_BUFS)) u_roles (
      .clk        (clk),
      .rst        (rst),
      .frame_start(frame_start),
      .swap_req   (swap_req),
      .swap_ack   (swap_ack),
      .disp_idx   (disp_idx),
      .write_sel  (write_sel),
      .drop_count (drop_count)
   );

   // Port A is the writer side, port B the display side.
   for (genvar g = 0; g < NUM_BUFS; g++) begin : g_buf
      logic             wr_hit;
      logic [WIDTH-1:0] douta_unused;

      assign wr_hit = write_enable & ~rst & (write_sel == BUF_IDX_W'(g));

      xilinx_true_dual_port_read_first_1_clock_ram #(
         .RAM_WIDTH(WIDTH),
         .RAM_DEPTH(DEPTH),
         .ADDR_LEN (ADDR_LEN)
      ) u_ram (
         .clka (clk),
         .addra(write_addr),
         .addrb(read_addr),
         .dina (write_data),
         .dinb ({WIDTH{1'b0}}),
         .wea  (wr_hit),
         .web  (1'b0),
         .ena  (wr_hit),
         .enb  (1'b1),
         .douta(douta_unused),
         .doutb(ram_dout[g])
      );
   end

   logic [BUF_IDX_W-1:0] rd_sel_q, rd_sel_d;
   logic                 rd_vld_q, rd_vld_d;
   logic [WIDTH-1:0]     rd_data_q, rd_data_d;
   logic [BUF_IDX_W-1:0] rd_buf_q, rd_buf_d;
   logic [WIDTH-1:0]     rd_word;

   // Stage 1 is the RAM output register; stage 2 picks the buffer that was
   // DISPLAY when the address was presented.
   always_comb begin
      rd_word = '0;
      for (int i = 0; i < NUM_BUFS; i++) begin
         if (rd_sel_q == i[BUF_IDX_W-1:0]) rd_word = ram_dout[i];
      end
      rd_sel_d  = disp_idx;
      rd_vld_d  = ~rst;
      rd_data_d = '0;
      rd_buf_d  = '0;
      if (!rst && rd_vld_q) begin
         rd_data_d = rd_word;
         rd_buf_d  = rd_sel_q;
      end
   end

   always_ff @(posedge clk) begin
      rd_sel_q  <= rd_sel_d;
      rd_vld_q  <= rd_vld_d;
      rd_data_q <= rd_data_d;
      rd_buf_q  <= rd_buf_d;
   end

   assign read_data_out = rd_data_q;
   assign read_buf_out  = rd_buf_q;
   assign write_buf_out = write_sel;
endmodule
`default_nettype wire

// File: doc/frame_buffer_ring.md
FRAME_BUFFER_RING -- requirements
Module: frame_buffer_ring

Interface
REQ-001 SHALL have parameter WIDTH, default `COLOR_BITS, bits per pixel word.
REQ-002 SHALL have parameter DEPTH, default 1<<`ADDR_BITS, words per buffer.
REQ-003 SHALL have parameter ADDR_LEN, default `ADDR_BITS, address width.
REQ-004 SHALL have parameter NUM_BUFS, default 3, legal range 2..4; BUF_IDX_W = 2.
REQ-005 SHALL have port clk input 1; all logic on posedge clk.
REQ-006 SHALL have port rst input 1; reset is synchronous, active-high.
REQ-007 SHALL have port frame_start input 1; display vsync pulse, one cycle.
REQ-008 SHALL have port swap_req input 1; writer finished frame, held high until swap_ack.
REQ-009 SHALL have port swap_ack output 1; one-cycle pulse when the request is accepted.
REQ-010 SHALL have port write_enable input 1; write strobe.
REQ-011 SHALL have port write_addr input ADDR_LEN; write address.
REQ-012 SHALL have port write_data input WIDTH; write word.
REQ-013 SHALL have port read_addr input ADDR_LEN; display read address.
REQ-014 SHALL have port read_data_out output WIDTH; display pixel word.
REQ-015 SHALL have port read_buf_out output BUF_IDX_W; buffer index that produced read_data_out.
REQ-016 SHALL have port write_buf_out output BUF_IDX_W; buffer currently owned by the writer.
REQ-017 SHALL have port drop_count output 16; frames completed but never displayed.

Function
REQ-018 SHALL track each buffer in exactly one role: DISPLAY, WRITE, READY or FREE; exactly one DISPLAY, one WRITE and at most one READY at all times.
REQ-019 SHALL route write_enable only to the WRITE buffer (registered index); writes in the swap_ack cycle still go to the old WRITE buffer.
REQ-020 SHALL present read_data_out 2 cycles after read_addr, from the DISPLAY buffer sampled with that address; read_buf_out delayed identically.
REQ-021 SHALL, on swap_req with a FREE buffer present: WRITE->READY, lowest-index FREE->WRITE, assert swap_ack the next cycle.
REQ-022 SHALL, if a READY buffer already existed at that swap, return it to FREE and increment drop_count (saturating at 16'hFFFF).
REQ-023 SHALL, on swap_req with no FREE buffer (NUM_BUFS=2), hold the request pending; at the next frame_start exchange DISPLAY and WRITE and assert swap_ack that cycle+1.
REQ-024 SHALL, on frame_start with a READY buffer: READY->DISPLAY, old DISPLAY->FREE; with no READY, roles unchanged.
REQ-025 SHALL, when swap acceptance and frame_start coincide, apply the swap first so the just-completed buffer becomes DISPLAY in the same update; no drop counted for it.
REQ-026 SHALL assert swap_ack for exactly one cycle per request and not re-accept until swap_req deasserts for at least one cycle.
REQ-027 SHALL keep port-B writes and port-A reads permanently disabled on the unused sides.

Reset
REQ-028 SHALL on rst: DISPLAY=0, WRITE=1, remaining FREE, no READY, swap_ack=0, drop_count=0, pending request cleared.
REQ-029 SHALL drive read_data_out=0 and read_buf_out=0 during and 2 cycles after rst; BRAM contents are not cleared.
REQ-030 SHALL discard any swap_req or frame_start asserted in a reset cycle.

Structure
REQ-031 SHALL place the role enum (DISPLAY/WRITE/READY/FREE) and BUF_IDX_W in the shared types package.
REQ-032 SHALL instantiate NUM_BUFS copies of xilinx_true_dual_port_read_first_1_clock_ram via generate; role tracking SHALL be a single sub-module fb_role_tracker.

Verification
REQ-033 Reset, NUM_BUFS=3 -> write_buf_out=1, read_buf_out=0, drop_count=0, swap_ack=0.
REQ-034 Write 0xA to addr 5 in buf 1, swap_req, frame_start, read addr 5 -> swap_ack one cycle after req, read_data_out=0xA with read_buf_out=1 2 cycles after address.
REQ-035 NUM_BUFS=3, two swaps without frame_start -> drop_count=1, first READY buffer FREE, write_buf_out cycles 1->2->1.
REQ-036 NUM_BUFS=2, swap_req held 10 cycles then frame_start -> swap_ack only after frame_start, display=1, write=0.
REQ-037 swap_req and frame_start same cycle, NUM_BUFS=3 -> completed buffer displayed next frame, drop_count unchanged.
REQ-038 rst asserted with request pending -> swap_ack never pulses, roles return to REQ-028 values.
